// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-port word memory.
// Optional ISSUE-phase timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_done,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_done,
  output logic                  bus_err,
  output logic [1:0]            grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_req_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_data_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  last_q, last_d;   // 1: m1 was granted most recently
  logic                  pick_m1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // On a tie the requester that did not win last time gets the bus.
  assign pick_m1 = m1_req & (~m0_req | ~last_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          state_d = ISSUE;
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          addr_d  = pick_m1 ? m1_addr  : m0_addr;
          we_d    = pick_m1 ? m1_we    : m0_we;
          wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          rdata_d = '0;
          last_d  = pick_m1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (mem_data_valid) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : mem_rdata;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      last_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign m0_done       = (state_q == RESP) & grant_q[0];
  assign m1_done       = (state_q == RESP) & grant_q[1];
  assign m0_rdata      = m0_done ? rdata_q : '0;
  assign m1_rdata      = m1_done ? rdata_q : '0;

`ifdef ARB_TIMEOUT_EN
  assign bus_err = (state_q == RESP) & err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [5:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_done, m1_done, bus_err;
  logic [1:0]  grant;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_req_valid, mem_data_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (6),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_req        (m0_req),
    .m0_addr       (m0_addr),
    .m0_we         (m0_we),
    .m0_wdata      (m0_wdata),
    .m0_rdata      (m0_rdata),
    .m0_done       (m0_done),
    .m1_req        (m1_req),
    .m1_addr       (m1_addr),
    .m1_we         (m1_we),
    .m1_wdata      (m1_wdata),
    .m1_rdata      (m1_rdata),
    .m1_done       (m1_done),
    .bus_err       (bus_err),
    .grant         (grant),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_req_valid (mem_req_valid),
    .mem_rdata     (mem_rdata),
    .mem_data_valid(mem_data_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bit exp_m1;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0; mem_data_valid = 0;

    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_vld", 32'(mem_req_valid), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);

    step(); reset = 1'b1;
    step();

    // m0 read of address 5, memory answers two cycles into ISSUE
    m0_req = 1; m0_addr = 6'd5; m0_we = 0;
    step();
    chk("t1_vld", 32'(mem_req_valid), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd5);
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_we", 32'(mem_we), 32'd0);
    m0_req = 0;
    step();
    chk("t1_vld_hold", 32'(mem_req_valid), 32'd1);
    chk("t1_early_done", 32'(m0_done), 32'd0);
    mem_data_valid = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_data_valid = 0; mem_rdata = '0;
    chk("t1_done", 32'(m0_done), 32'd1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_resp_grant", 32'(grant), 32'd1);
    chk("t1_resp_vld", 32'(mem_req_valid), 32'd0);
    chk("t1_m1_done", 32'(m1_done), 32'd0);
    chk("t1_m1_rdata", m1_rdata, 32'd0);
    chk("t1_err", 32'(bus_err), 32'd0);
    step();
    chk("t1_done_pulse", 32'(m0_done), 32'd0);
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_rdata_clr", m0_rdata, 32'd0);

    // stray mem_data_valid while idle
    mem_data_valid = 1; mem_rdata = 32'h5A5A5A5A;
    step();
    mem_data_valid = 0; mem_rdata = '0;
    chk("t2_done", {30'd0, m1_done, m0_done}, 32'd0);
    chk("t2_vld", 32'(mem_req_valid), 32'd0);
    chk("t2_grant", 32'(grant), 32'd0);
    step();
    chk("t2_still_idle", {29'd0, mem_req_valid, grant}, 32'd0);

    // m1 write to the top address; request inputs change after capture
    m1_req = 1; m1_addr = 6'd63; m1_we = 1; m1_wdata = 32'h12345678;
    step();
    chk("t3_vld", 32'(mem_req_valid), 32'd1);
    chk("t3_we", 32'(mem_we), 32'd1);
    chk("t3_addr", 32'(mem_addr), 32'd63);
    chk("t3_wdata", mem_wdata, 32'h12345678);
    chk("t3_grant", 32'(grant), 32'd2);
    m1_req = 0; m1_addr = '0; m1_we = 0; m1_wdata = 32'hFFFFFFFF;
    step();
    chk("t3_addr_hold", 32'(mem_addr), 32'd63);
    chk("t3_wdata_hold", mem_wdata, 32'h12345678);
    chk("t3_we_hold", 32'(mem_we), 32'd1);
    mem_data_valid = 1; mem_rdata = 32'hAAAA5555;
    step();
    mem_data_valid = 0; mem_rdata = '0;
    chk("t3_done", 32'(m1_done), 32'd1);
    chk("t3_rdata", m1_rdata, 32'd0);
    chk("t3_m0_done", 32'(m0_done), 32'd0);
    chk("t3_m0_rdata", m0_rdata, 32'd0);
    step();
    chk("t3_done_pulse", 32'(m1_done), 32'd0);
    chk("t3_idle", {29'd0, mem_req_valid, grant}, 32'd0);

    // asynchronous reset in the middle of ISSUE
    m0_req = 1; m0_addr = 6'd9; m0_we = 0;
    step();
    chk("t4_vld", 32'(mem_req_valid), 32'd1);
    m0_req = 0;
    #2 reset = 1'b0;
    #1;
    chk("t4_vld_rst", 32'(mem_req_valid), 32'd0);
    chk("t4_grant_rst", 32'(grant), 32'd0);
    chk("t4_addr_rst", 32'(mem_addr), 32'd0);
    step();
    chk("t4_no_done", {30'd0, m1_done, m0_done}, 32'd0);

    // both masters request together right after reset and hold
    m0_req = 1; m0_addr = 6'd1; m0_we = 0;
    m1_req = 1; m1_addr = 6'd2; m1_we = 0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_m1 = (i % 2) == 1;
      step();
      chk("t5_grant", 32'(grant), exp_m1 ? 32'd2 : 32'd1);
      chk("t5_addr", 32'(mem_addr), exp_m1 ? 32'd2 : 32'd1);
      chk("t5_vld", 32'(mem_req_valid), 32'd1);
      mem_data_valid = 1; mem_rdata = 32'h100 + 32'(i);
      step();
      mem_data_valid = 0; mem_rdata = '0;
      chk("t5_m0_done", 32'(m0_done), exp_m1 ? 32'd0 : 32'd1);
      chk("t5_m1_done", 32'(m1_done), exp_m1 ? 32'd1 : 32'd0);
      chk("t5_m0_rdata", m0_rdata, exp_m1 ? 32'd0 : 32'h100 + 32'(i));
      chk("t5_m1_rdata", m1_rdata, exp_m1 ? 32'h100 + 32'(i) : 32'd0);
      step();
      chk("t5_idle_grant", 32'(grant), 32'd0);
    end
    m0_req = 0; m1_req = 0;
    step();
    chk("t5_quiet", {29'd0, mem_req_valid, grant}, 32'd0);

    // memory that never answers
    m0_req = 1; m0_addr = 6'd7; m0_we = 0;
    step();
    m0_req = 0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      chk("t6_vld", 32'(mem_req_valid), 32'd1);
      chk("t6_no_done", 32'(m0_done), 32'd0);
      step();
    end
    chk("t6_done", 32'(m0_done), 32'd1);
    chk("t6_err", 32'(bus_err), 32'd1);
    chk("t6_rdata", m0_rdata, 32'd0);
    step();
    chk("t6_after", {29'd0, m0_done, bus_err, mem_req_valid}, 32'd0);
`else
    for (int k = 1; k <= 20; k++) begin
      chk("t6_vld", 32'(mem_req_valid), 32'd1);
      chk("t6_err", 32'(bus_err), 32'd0);
      chk("t6_no_done", 32'(m0_done), 32'd0);
      step();
    end
    mem_data_valid = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_data_valid = 0; mem_rdata = '0;
    chk("t6_late_done", 32'(m0_done), 32'd1);
    chk("t6_late_rdata", m0_rdata, 32'hCAFEF00D);
    chk("t6_late_err", 32'(bus_err), 32'd0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
